// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single instruction/data memory port between the fetch stage and
// the LSU. At most one transaction is outstanding. The winning request is
// captured into the memory-side output registers, the memory response is
// routed back to whichever requester owns the transaction, and the next
// pending request is picked up in the same cycle the response arrives so
// back-to-back transactions have no idle bubble.
//
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   - ties between fetch and LSU go to the requester not served last
//   undefined - fixed LSU-over-fetch priority (an older instruction is
//               waiting on the LSU)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; arbitrate any incoming request
// ADDR  | mem_req high, address/control held stable until mem_gnt
// RESP  | request accepted, waiting for mem_rvalid; re-arbitrate on it

module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              lsu_read_en,
    input  logic              lsu_write_en,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [1:0]        lsu_store_size,
    input  logic [DATA_W-1:0] lsu_store_data,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        LSU   = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t state;
    state_t state_nxt;
    owner_t owner;

    logic lsu_req;
    logic resp_done;
    logic cand_if;
    logic cand_lsu;
    logic arb_valid;
    logic pick_lsu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t last;
`endif

    assign lsu_req   = lsu_read_en | lsu_write_en;
    assign resp_done = (state == RESP) & mem_rvalid;

    // Candidate requesters: everyone in IDLE; on completion only the requester
    // that was not just served, since its request line is still high this cycle.
    always_comb begin
        cand_if  = 1'b0;
        cand_lsu = 1'b0;
        if (state == IDLE) begin
            cand_if  = if_req;
            cand_lsu = lsu_req;
        end else if (resp_done) begin
            cand_if  = if_req  & (owner == LSU);
            cand_lsu = lsu_req & (owner == FETCH);
        end
    end

    // Winner selection among the candidates.
    always_comb begin
        arb_valid = cand_if | cand_lsu;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_lsu  = cand_lsu & (~cand_if | (last == FETCH));
`else
        pick_lsu  = cand_lsu;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (mem_gnt) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_nxt = arb_valid ? ADDR : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winning request into the memory-side registers; they stay
    // stable until the next winner is chosen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= FETCH;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_size  <= 2'b00;
            mem_wdata <= '0;
        end else if (arb_valid) begin
            if (pick_lsu) begin
                owner     <= LSU;
                mem_we    <= lsu_write_en;
                mem_addr  <= lsu_addr;
                mem_size  <= lsu_write_en ? lsu_store_size : SIZE_WORD;
                mem_wdata <= lsu_store_data;
            end else begin
                owner     <= FETCH;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_size  <= SIZE_WORD;
                mem_wdata <= '0;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember who was served most recently to break the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= FETCH;
        end else if (arb_valid) begin
            last <= pick_lsu ? LSU : FETCH;
        end
    end
`endif

    assign mem_req    = (state == ADDR);
    assign if_rvalid  = resp_done & (owner == FETCH);
    assign lsu_rvalid = resp_done & (owner == LSU);
    assign if_rdata   = mem_rdata;
    assign lsu_rdata  = mem_rdata;

    assign stall = (if_req & ~if_rvalid) | (lsu_req & ~lsu_rvalid);

endmodule
